arp_mac_rewrite: RTL and testbench
==================================

# arp_mac_rewrite

Parametrised ARP resolution and header-rewrite stage for the router output-port-lookup pipeline, placed directly after the LPM stage. It buffers the AXI-Stream packet and takes one lookup request per packet (next-hop IP plus egress one-hot port) from the LPM stage. It searches an internal, software-written ARP table of configurable depth, rewrites the Ethernet and IP header on a hit, and diverts misses to the CPU queue of the ingress port. Hit and miss counters are exported for the register block.

## Interface
- C_M_AXIS_DATA_WIDTH, 256, output stream data width (≥256, header layout fixed in the top 256 bits)
- C_S_AXIS_DATA_WIDTH, 256, input stream data width (must equal master width)
- C_M_AXIS_TUSER_WIDTH / C_S_AXIS_TUSER_WIDTH, 128, sideband width
- SRC_PORT_POS, 16, TUSER bit offset of the 8-bit one-hot source port
- DST_PORT_POS, 24, TUSER bit offset of the 8-bit one-hot destination port
- ARP_ADDR_BITS, 5, table depth = 2^ARP_ADDR_BITS entries
- NUM_PORTS, 4, physical ports; port p uses DST bit 2p, its CPU queue uses bit 2p+1
- FIFO_DEPTH_BITS, 2, log2 depth of the packet buffer
- AXI_ACLK in 1 clock
- AXI_RESET in 1 asynchronous, active-high reset
- S_AXIS_TDATA/TSTRB/TUSER/TVALID/TREADY/TLAST: slave stream, standard AXI-Stream widths
- M_AXIS_TDATA/TSTRB/TUSER/TVALID/TREADY/TLAST: master stream
- meta_valid in 1: lookup request valid, one per packet, in packet order
- meta_ready out 1: request accepted
- meta_lpm_hit in 1: 0 means no route; the packet passes through untouched
- meta_next_hop in 32: next-hop IPv4 address
- meta_oq in 8: one-hot egress DST_PORT value chosen by LPM
- port_mac in 48*NUM_PORTS: source MAC of port p at bits [48p+47:48p]
- tbl_wr_en in 1: table write strobe
- tbl_wr_addr in ARP_ADDR_BITS: entry index
- tbl_wr_valid in 1: entry valid bit
- tbl_wr_ip in 32, tbl_wr_mac in 48: entry contents
- arp_hit_count out 32, arp_miss_count out 32: wrapping counters

## Operation
- Packet buffer: fallthrough FIFO; S_AXIS_TREADY = !nearly_full.
- FSM states: WAIT_META, LOOKUP, HEAD, BODY.
- WAIT_META: when meta_valid and FIFO non-empty, assert meta_ready for one cycle, latch the request, then go to LOOKUP.
- LOOKUP (1 cycle): compare meta_next_hop against all valid entries in parallel; the lowest matching index wins. Register hit, MAC, and index. Go to HEAD.
- Bypass: if meta_lpm_hit=0 or the incoming TUSER DST field ≠ 0, the first beat is forwarded unmodified and no counter changes.
- HEAD, hit: TDATA[255:208] = entry MAC; TDATA[207:160] = port_mac of the port whose DST bit 2p is set in meta_oq; TUSER DST field = meta_oq; arp_hit_count +1.
- HEAD, miss: data unchanged; DST field = source one-hot shifted left by 1 (CPU queue); arp_miss_count +1.
- Beat transfer on TVALID&TREADY: TLAST goes to WAIT_META, otherwise to BODY.
- BODY: beats pass through unmodified; TLAST&TVALID&TREADY goes to WAIT_META.
- Table writes land at the clock edge. A write coincident with LOOKUP does not affect that lookup.
- Counters wrap from 0xFFFFFFFF to 0.

## Timing
- Reset (async assert, sync release): state = WAIT_META; M_AXIS_TVALID = 0, meta_ready = 0, S_AXIS_TREADY = 0 while reset is asserted; counters = 0; all entries invalid.
- First beat appears on M_AXIS at least 2 cycles after the meta handshake cycle.
- Body throughput: 1 beat per cycle.
- M_AXIS_TVALID is deasserted in WAIT_META and LOOKUP.
- Master outputs hold stable while TVALID=1 and TREADY=0.
- Reset mid-packet: FIFO and FSM are flushed; partial packets are discarded.

## Configuration
- ARP_TTL_REWRITE_EN defined: on a hit, TDATA[79:72] (TTL) −1 and TDATA[63:48] (checksum) incrementally updated, +16'h0100 with end-around carry. Hits with TTL ≤ 1 are instead sent to the CPU queue unmodified and counted as misses.
- ARP_TTL_REWRITE_EN undefined: only the MACs and DST field are rewritten; TTL and checksum pass through.

## Structure
- Shared package: header bit-position constants (DMAC, SMAC, TTL, CSUM), FSM state encoding, and the table entry typedef {valid, ip[31:0], mac[47:0]}.
- Sub-module: reuse fallthrough_small_fifo for the packet buffer.
- The table and parallel compare stay inline.

## Test plan
- Write entry 3 = {10.0.0.2, 00:11:22:33:44:55}; send a packet with next_hop 10.0.0.2, oq 0x04 -> DMAC 001122334455, SMAC = port_mac[1], DST 0x04, hit_count 1.
- Same packet with next_hop 10.0.0.9 (absent), source 0x10 -> DST 0x20, data unchanged, miss_count 1.
- Duplicate IP in entries 5 and 2 -> MAC of entry 2 used.
- ARP_TTL_REWRITE_EN: TTL 0x40, checksum 0xFFFE -> TTL 0x3F, checksum 0x00FF. TTL 0x01 -> CPU queue, miss_count +1.
- Three back-to-back 1-, 2-, and 5-beat packets with random TREADY stalls -> output beats identical except the header fields, order preserved, no TLAST loss.
- Assert AXI_RESET during BODY -> TVALID low immediately; the next packet after release is processed correctly and counters read 0.

Source files
------------

// File: rtl/arp_mac_rewrite_pkg.sv
// Shared definitions for the ARP resolution / header rewrite stage:
// header field positions, FSM state encoding, ARP table entry layout
// and the incremental checksum helper used by the TTL rewrite option.
`timescale 1ns/1ps

package arp_mac_rewrite_pkg;

    // Ethernet / IPv4 header field positions within the first beat
    localparam int DMAC_HI = 255;
    localparam int DMAC_LO = 208;
    localparam int SMAC_HI = 207;
    localparam int SMAC_LO = 160;
    localparam int TTL_HI  = 79;
    localparam int TTL_LO  = 72;
    localparam int CSUM_HI = 63;
    localparam int CSUM_LO = 48;

    typedef enum logic [1:0] {
        WAIT_META = 2'd0,
        LOOKUP    = 2'd1,
        HEAD      = 2'd2,
        BODY      = 2'd3
    } state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] ip;
        logic [47:0] mac;
    } arp_entry_t;

    // Decrementing TTL lowers the header sum by 0x0100, so the stored
    // one's-complement checksum rises by 0x0100 with end-around carry.
    function automatic logic [15:0] csum_add_0100(input logic [15:0] csum);
        logic [16:0] sum;
        sum = {1'b0, csum} + 17'h00100;
        return sum[15:0] + {15'd0, sum[16]};
    endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fallthrough FIFO: the head entry is visible on dout
// whenever empty is low, and rd_en pops it. nearly_full asserts with one
// free slot left so a registered producer can stop in time.
`timescale 1ns/1ps

module fallthrough_small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 2
) (
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty,
    input  logic             reset,
    input  logic             clk
);

    localparam int DEPTH = 1 << MAX_DEPTH_BITS;

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic [MAX_DEPTH_BITS:0]   depth;

    // Storage array; contents need no reset because depth gates visibility
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking, flushed by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            depth  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + MAX_DEPTH_BITS'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + MAX_DEPTH_BITS'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   depth <= depth + (MAX_DEPTH_BITS+1)'(1);
                2'b01:   depth <= depth - (MAX_DEPTH_BITS+1)'(1);
                default: depth <= depth;
            endcase
        end
    end

    assign dout        = mem[rd_ptr];
    assign empty       = (depth == '0);
    assign nearly_full = (depth >= (MAX_DEPTH_BITS+1)'(DEPTH - 1));

endmodule

// File: rtl/arp_mac_rewrite.sv
// ARP resolution and header rewrite stage placed after the LPM lookup.
// Packets are buffered in a fallthrough FIFO while the next-hop IP from
// the LPM stage is resolved against a software-written ARP table. Hits
// get their destination/source MACs and DST port rewritten; misses are
// steered to the CPU queue of the ingress port.
// Optional feature macro: ARP_TTL_REWRITE_EN -- on a hit also decrement
// TTL and patch the IPv4 checksum; hits with TTL <= 1 go to the CPU queue.
`timescale 1ns/1ps

module arp_mac_rewrite
    import arp_mac_rewrite_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int SRC_PORT_POS         = 16,
    parameter int DST_PORT_POS         = 24,
    parameter int ARP_ADDR_BITS        = 5,
    parameter int NUM_PORTS            = 4,
    parameter int FIFO_DEPTH_BITS      = 2
) (
    input  logic                                AXI_ACLK,
    input  logic                                AXI_RESET,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      S_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    S_AXIS_TSTRB,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     S_AXIS_TUSER,
    input  logic                                S_AXIS_TVALID,
    output logic                                S_AXIS_TREADY,
    input  logic                                S_AXIS_TLAST,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]      M_AXIS_TDATA,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    M_AXIS_TSTRB,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     M_AXIS_TUSER,
    output logic                                M_AXIS_TVALID,
    input  logic                                M_AXIS_TREADY,
    output logic                                M_AXIS_TLAST,

    input  logic                                meta_valid,
    output logic                                meta_ready,
    input  logic                                meta_lpm_hit,
    input  logic [31:0]                         meta_next_hop,
    input  logic [7:0]                          meta_oq,

    input  logic [48*NUM_PORTS-1:0]             port_mac,

    input  logic                                tbl_wr_en,
    input  logic [ARP_ADDR_BITS-1:0]            tbl_wr_addr,
    input  logic                                tbl_wr_valid,
    input  logic [31:0]                         tbl_wr_ip,
    input  logic [47:0]                         tbl_wr_mac,

    output logic [31:0]                         arp_hit_count,
    output logic [31:0]                         arp_miss_count
);

    localparam int DW        = C_S_AXIS_DATA_WIDTH;
    localparam int SW        = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UW        = C_S_AXIS_TUSER_WIDTH;
    localparam int FIFO_W    = DW + SW + UW + 1;
    localparam int TBL_DEPTH = 1 << ARP_ADDR_BITS;

    state_t state;
    state_t next_state;

    logic [FIFO_W-1:0] fifo_din;
    logic [FIFO_W-1:0] fifo_dout;
    logic              fifo_wr;
    logic              fifo_rd;
    logic              fifo_empty;
    logic              fifo_nearly_full;

    logic [DW-1:0]     fifo_data;
    logic [SW-1:0]     fifo_strb;
    logic [UW-1:0]     fifo_user;
    logic              fifo_last;

    logic              req_lpm_hit;
    logic [31:0]       req_next_hop;
    logic [7:0]        req_oq;

    arp_entry_t        arp_table [TBL_DEPTH];
    logic              lk_hit;
    logic [47:0]       lk_mac;
    logic              hit_q;
    logic [47:0]       mac_q;

    logic              beat_xfer;
    logic              head_bypass;
    logic              ttl_expired;
    logic              count_hit;
    logic              count_miss;
    logic [47:0]       egress_smac;
    logic [DW-1:0]     out_data;
    logic [UW-1:0]     out_user;

    assign fifo_din = {S_AXIS_TLAST, S_AXIS_TUSER, S_AXIS_TSTRB, S_AXIS_TDATA};
    assign fifo_wr  = S_AXIS_TVALID & S_AXIS_TREADY;
    assign fifo_rd  = beat_xfer;

    assign fifo_data = fifo_dout[DW-1:0];
    assign fifo_strb = fifo_dout[DW +: SW];
    assign fifo_user = fifo_dout[DW+SW +: UW];
    assign fifo_last = fifo_dout[FIFO_W-1];

    fallthrough_small_fifo #(
        .WIDTH          (FIFO_W),
        .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
    ) pkt_fifo (
        .din         (fifo_din),
        .wr_en       (fifo_wr),
        .rd_en       (fifo_rd),
        .dout        (fifo_dout),
        .nearly_full (fifo_nearly_full),
        .empty       (fifo_empty),
        .reset       (AXI_RESET),
        .clk         (AXI_ACLK)
    );

    assign S_AXIS_TREADY = !fifo_nearly_full && !AXI_RESET;
    assign M_AXIS_TVALID = ((state == HEAD) || (state == BODY)) && !fifo_empty;
    assign beat_xfer     = M_AXIS_TVALID & M_AXIS_TREADY;

    // FSM state register
    always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
        if (AXI_RESET) begin
            state <= WAIT_META;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and lookup-request handshake
    always_comb begin
        next_state = state;
        meta_ready = 1'b0;
        case (state)
            WAIT_META: begin
                if (meta_valid && !fifo_empty) begin
                    meta_ready = 1'b1;
                    next_state = LOOKUP;
                end
            end
            LOOKUP: begin
                next_state = HEAD;
            end
            HEAD: begin
                if (beat_xfer) begin
                    next_state = fifo_last ? WAIT_META : BODY;
                end
            end
            BODY: begin
                if (beat_xfer && fifo_last) begin
                    next_state = WAIT_META;
                end
            end
            default: begin
                next_state = WAIT_META;
            end
        endcase
    end

    // Hold the accepted lookup request for the whole packet
    always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
        if (AXI_RESET) begin
            req_lpm_hit  <= 1'b0;
            req_next_hop <= '0;
            req_oq       <= '0;
        end else if (meta_ready) begin
            req_lpm_hit  <= meta_lpm_hit;
            req_next_hop <= meta_next_hop;
            req_oq       <= meta_oq;
        end
    end

    // Software table writes; reset invalidates every entry
    always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
        if (AXI_RESET) begin
            for (int i = 0; i < TBL_DEPTH; i++) begin
                arp_table[i] <= '0;
            end
        end else if (tbl_wr_en) begin
            arp_table[tbl_wr_addr] <= {tbl_wr_valid, tbl_wr_ip, tbl_wr_mac};
        end
    end

    // Parallel compare; scanning downward lets the lowest index win
    always_comb begin
        lk_hit = 1'b0;
        lk_mac = '0;
        for (int i = TBL_DEPTH - 1; i >= 0; i--) begin
            if (arp_table[i].valid && (arp_table[i].ip == req_next_hop)) begin
                lk_hit = 1'b1;
                lk_mac = arp_table[i].mac;
            end
        end
    end

    // Capture the lookup result in the single LOOKUP cycle
    always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
        if (AXI_RESET) begin
            hit_q <= 1'b0;
            mac_q <= '0;
        end else if (state == LOOKUP) begin
            hit_q <= lk_hit;
            mac_q <= lk_mac;
        end
    end

    // Source MAC of the egress port; lowest selected port wins
    always_comb begin
        egress_smac = fifo_data[SMAC_HI:SMAC_LO];
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (req_oq[2*p]) begin
                egress_smac = port_mac[48*p +: 48];
            end
        end
    end

    // Header rewrite of the first beat; later beats pass untouched
    always_comb begin
        out_data    = fifo_data;
        out_user    = fifo_user;
        count_hit   = 1'b0;
        count_miss  = 1'b0;
        head_bypass = !req_lpm_hit || (fifo_user[DST_PORT_POS +: 8] != 8'd0);
`ifdef ARP_TTL_REWRITE_EN
        ttl_expired = (fifo_data[TTL_HI:TTL_LO] <= 8'd1);
`else
        ttl_expired = 1'b0;
`endif
        if ((state == HEAD) && !head_bypass) begin
            if (hit_q && !ttl_expired) begin
                out_data[DMAC_HI:DMAC_LO]   = mac_q;
                out_data[SMAC_HI:SMAC_LO]   = egress_smac;
                out_user[DST_PORT_POS +: 8] = req_oq;
`ifdef ARP_TTL_REWRITE_EN
                out_data[TTL_HI:TTL_LO]     = fifo_data[TTL_HI:TTL_LO] - 8'd1;
                out_data[CSUM_HI:CSUM_LO]   = csum_add_0100(fifo_data[CSUM_HI:CSUM_LO]);
`endif
                count_hit = 1'b1;
            end else begin
                out_user[DST_PORT_POS +: 8] = {fifo_user[SRC_PORT_POS +: 7], 1'b0};
                count_miss = 1'b1;
            end
        end
    end

    assign M_AXIS_TDATA = out_data;
    assign M_AXIS_TSTRB = fifo_strb;
    assign M_AXIS_TUSER = out_user;
    assign M_AXIS_TLAST = fifo_last;

    // Hit/miss statistics, counted when the header beat leaves the stage
    always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
        if (AXI_RESET) begin
            arp_hit_count  <= '0;
            arp_miss_count <= '0;
        end else if (beat_xfer) begin
            if (count_hit) begin
                arp_hit_count <= arp_hit_count + 32'd1;
            end
            if (count_miss) begin
                arp_miss_count <= arp_miss_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_arp_mac_rewrite.sv
// Scoreboard bench for arp_mac_rewrite: stimulus tasks push expected
// beats into a queue, and an independent monitor compares every beat
// the DUT emits. Expected header values are hand-written constants.
`timescale 1ns/1ps

module tb_arp_mac_rewrite;

    localparam logic [47:0] PMAC0  = 48'h02_00_00_00_00_10;
    localparam logic [47:0] PMAC1  = 48'h02_00_00_00_00_20;
    localparam logic [47:0] PMAC2  = 48'h02_00_00_00_00_30;
    localparam logic [47:0] PMAC3  = 48'h02_00_00_00_00_40;
    localparam logic [47:0] MAC_A  = 48'h00_11_22_33_44_55;
    localparam logic [47:0] MAC_E2 = 48'hAA_BB_CC_DD_EE_02;
    localparam logic [47:0] MAC_E5 = 48'hAA_BB_CC_DD_EE_05;
    localparam logic [47:0] MAC_E7 = 48'hAA_BB_CC_DD_EE_07;
`ifdef ARP_TTL_REWRITE_EN
    localparam logic [7:0]  HIT_TTL  = 8'h3F;
    localparam logic [15:0] HIT_CSUM = 16'h00FF;
`else
    localparam logic [7:0]  HIT_TTL  = 8'h40;
    localparam logic [15:0] HIT_CSUM = 16'hFFFE;
`endif

    typedef struct {
        logic [255:0] data;
        logic [127:0] user;
        logic         last;
    } beat_t;

    typedef struct {
        logic        lpm;
        logic [31:0] nh;
        logic [7:0]  oq;
    } meta_t;

    logic         AXI_ACLK = 1'b0;
    logic         AXI_RESET;
    logic [255:0] S_AXIS_TDATA;
    logic [31:0]  S_AXIS_TSTRB;
    logic [127:0] S_AXIS_TUSER;
    logic         S_AXIS_TVALID;
    logic         S_AXIS_TREADY;
    logic         S_AXIS_TLAST;
    logic [255:0] M_AXIS_TDATA;
    logic [31:0]  M_AXIS_TSTRB;
    logic [127:0] M_AXIS_TUSER;
    logic         M_AXIS_TVALID;
    logic         M_AXIS_TREADY;
    logic         M_AXIS_TLAST;
    logic         meta_valid;
    logic         meta_ready;
    logic         meta_lpm_hit;
    logic [31:0]  meta_next_hop;
    logic [7:0]   meta_oq;
    logic [191:0] port_mac;
    logic         tbl_wr_en;
    logic [4:0]   tbl_wr_addr;
    logic         tbl_wr_valid;
    logic [31:0]  tbl_wr_ip;
    logic [47:0]  tbl_wr_mac;
    logic [31:0]  arp_hit_count;
    logic [31:0]  arp_miss_count;

    beat_t inQ[$];
    beat_t expQ[$];
    meta_t metaQ[$];

    int  checks   = 0;
    int  errors   = 0;
    int  outBeats = 0;
    bit  abortDrv = 1'b0;
    bit  stallEn  = 1'b0;

    arp_mac_rewrite dut (
        .AXI_ACLK       (AXI_ACLK),
        .AXI_RESET      (AXI_RESET),
        .S_AXIS_TDATA   (S_AXIS_TDATA),
        .S_AXIS_TSTRB   (S_AXIS_TSTRB),
        .S_AXIS_TUSER   (S_AXIS_TUSER),
        .S_AXIS_TVALID  (S_AXIS_TVALID),
        .S_AXIS_TREADY  (S_AXIS_TREADY),
        .S_AXIS_TLAST   (S_AXIS_TLAST),
        .M_AXIS_TDATA   (M_AXIS_TDATA),
        .M_AXIS_TSTRB   (M_AXIS_TSTRB),
        .M_AXIS_TUSER   (M_AXIS_TUSER),
        .M_AXIS_TVALID  (M_AXIS_TVALID),
        .M_AXIS_TREADY  (M_AXIS_TREADY),
        .M_AXIS_TLAST   (M_AXIS_TLAST),
        .meta_valid     (meta_valid),
        .meta_ready     (meta_ready),
        .meta_lpm_hit   (meta_lpm_hit),
        .meta_next_hop  (meta_next_hop),
        .meta_oq        (meta_oq),
        .port_mac       (port_mac),
        .tbl_wr_en      (tbl_wr_en),
        .tbl_wr_addr    (tbl_wr_addr),
        .tbl_wr_valid   (tbl_wr_valid),
        .tbl_wr_ip      (tbl_wr_ip),
        .tbl_wr_mac     (tbl_wr_mac),
        .arp_hit_count  (arp_hit_count),
        .arp_miss_count (arp_miss_count)
    );

    // Free-running clock
    always #5 AXI_ACLK = ~AXI_ACLK;

    // Recognisable per-packet/per-beat pattern with a fixed TTL/checksum
    function automatic beat_t mkBeat(input int pkt, input int idx, input int n,
                                     input logic [7:0] src, input logic [7:0] dst,
                                     input logic [7:0] ttl);
        beat_t b;
        for (int k = 0; k < 16; k++) begin
            b.data[16*k +: 16] = {8'(pkt), 4'(k), 4'(idx)};
        end
        if (idx == 0) begin
            b.data[79:72] = ttl;
            b.data[63:48] = 16'hFFFE;
        end
        b.user        = '0;
        b.user[15:0]  = 16'(n * 32);
        b.user[23:16] = src;
        b.user[31:24] = dst;
        b.last        = (idx == n - 1);
        return b;
    endfunction

    // Queue one packet, its lookup request and its expected output
    task automatic applyStimulus(input int pkt, input int n,
                                 input logic [7:0] src, input logic [7:0] dstIn,
                                 input logic lpm, input logic [31:0] nh,
                                 input logic [7:0] oq, input logic rewrite,
                                 input logic [7:0] expDst, input logic [47:0] expMac,
                                 input logic [47:0] expSmac, input logic [7:0] ttlIn = 8'h40);
        beat_t b;
        beat_t e;
        meta_t m;
        for (int i = 0; i < n; i++) begin
            b = mkBeat(pkt, i, n, src, dstIn, ttlIn);
            e = b;
            if (i == 0) begin
                e.user[31:24] = expDst;
                if (rewrite) begin
                    e.data[255:208] = expMac;
                    e.data[207:160] = expSmac;
                    e.data[79:72]   = HIT_TTL;
                    e.data[63:48]   = HIT_CSUM;
                end
            end
            inQ.push_back(b);
            expQ.push_back(e);
        end
        m.lpm = lpm;
        m.nh  = nh;
        m.oq  = oq;
        metaQ.push_back(m);
    endtask

    task automatic writeEntry(input logic [4:0] addr, input logic v,
                              input logic [31:0] ip, input logic [47:0] mac);
        @(posedge AXI_ACLK);
        #1;
        tbl_wr_en    = 1'b1;
        tbl_wr_addr  = addr;
        tbl_wr_valid = v;
        tbl_wr_ip    = ip;
        tbl_wr_mac   = mac;
        @(posedge AXI_ACLK);
        #1;
        tbl_wr_en = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((expQ.size() != 0 || inQ.size() != 0 || metaQ.size() != 0) && n < 3000) begin
            @(posedge AXI_ACLK);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: %0d beats still expected, required 0", expQ.size());
            expQ.delete();
        end
        repeat (3) @(posedge AXI_ACLK);
    endtask

    task automatic checkOutput(input logic [31:0] hitExp, input logic [31:0] missExp);
        @(negedge AXI_ACLK);
        checks += 2;
        if (arp_hit_count !== hitExp) begin
            errors++;
            $display("[TB] FAIL hit_count: got %0d, required %0d", arp_hit_count, hitExp);
        end
        if (arp_miss_count !== missExp) begin
            errors++;
            $display("[TB] FAIL miss_count: got %0d, required %0d", arp_miss_count, missExp);
        end
    endtask

    // Slave-stream driver: presents queued beats until accepted
    initial begin
        beat_t b;
        bit acc;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TDATA  = '0;
        S_AXIS_TUSER  = '0;
        S_AXIS_TLAST  = 1'b0;
        S_AXIS_TSTRB  = 32'hFFFF_FFFF;
        @(posedge AXI_ACLK);
        #1;
        forever begin
            if (inQ.size() == 0) begin
                S_AXIS_TVALID = 1'b0;
                @(posedge AXI_ACLK);
                #1;
            end else begin
                b = inQ.pop_front();
                S_AXIS_TDATA  = b.data;
                S_AXIS_TUSER  = b.user;
                S_AXIS_TLAST  = b.last;
                S_AXIS_TVALID = 1'b1;
                acc = 1'b0;
                while (!acc) begin
                    @(negedge AXI_ACLK);
                    acc = S_AXIS_TREADY;
                    @(posedge AXI_ACLK);
                    #1;
                    if (abortDrv) acc = 1'b1;
                end
            end
        end
    end

    // Lookup-request driver: one request per packet, in order
    initial begin
        meta_t m;
        bit acc;
        meta_valid    = 1'b0;
        meta_lpm_hit  = 1'b0;
        meta_next_hop = '0;
        meta_oq       = '0;
        @(posedge AXI_ACLK);
        #1;
        forever begin
            if (metaQ.size() == 0) begin
                meta_valid = 1'b0;
                @(posedge AXI_ACLK);
                #1;
            end else begin
                m = metaQ.pop_front();
                meta_lpm_hit  = m.lpm;
                meta_next_hop = m.nh;
                meta_oq       = m.oq;
                meta_valid    = 1'b1;
                acc = 1'b0;
                while (!acc) begin
                    @(negedge AXI_ACLK);
                    acc = meta_ready;
                    @(posedge AXI_ACLK);
                    #1;
                    if (abortDrv) acc = 1'b1;
                end
                meta_valid = 1'b0;
            end
        end
    end

    // Master back-pressure: always ready, or random stalls when enabled
    initial begin
        M_AXIS_TREADY = 1'b1;
        forever begin
            @(posedge AXI_ACLK);
            #1;
            M_AXIS_TREADY = stallEn ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on each transfer and checks stall hold
    initial begin
        beat_t e;
        bit held = 1'b0;
        logic [255:0] hData;
        logic [127:0] hUser;
        logic hLast;
        forever begin
            @(negedge AXI_ACLK);
            if (AXI_RESET) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    checks++;
                    if (M_AXIS_TVALID !== 1'b1 || M_AXIS_TDATA !== hData ||
                        M_AXIS_TUSER !== hUser || M_AXIS_TLAST !== hLast) begin
                        errors++;
                        $display("[TB] FAIL stall_hold: valid=%b user=%h, required valid=1 user=%h",
                                 M_AXIS_TVALID, M_AXIS_TUSER, hUser);
                    end
                end
                if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                    held = 1'b0;
                    outBeats++;
                    checks++;
                    if (expQ.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_beat: data=%h, required no beat", M_AXIS_TDATA);
                    end else begin
                        e = expQ.pop_front();
                        if (M_AXIS_TDATA !== e.data || M_AXIS_TUSER !== e.user ||
                            M_AXIS_TLAST !== e.last || M_AXIS_TSTRB !== 32'hFFFF_FFFF) begin
                            errors++;
                            $display("[TB] FAIL beat: data=%h user=%h last=%b, required data=%h user=%h last=%b",
                                     M_AXIS_TDATA, M_AXIS_TUSER, M_AXIS_TLAST, e.data, e.user, e.last);
                        end
                    end
                end else if (M_AXIS_TVALID) begin
                    held  = 1'b1;
                    hData = M_AXIS_TDATA;
                    hUser = M_AXIS_TUSER;
                    hLast = M_AXIS_TLAST;
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    // Global watchdog
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main directed sequence
    initial begin
        int n;
        int startBeats;
        AXI_RESET    = 1'b1;
        port_mac     = {PMAC3, PMAC2, PMAC1, PMAC0};
        tbl_wr_en    = 1'b0;
        tbl_wr_addr  = '0;
        tbl_wr_valid = 1'b0;
        tbl_wr_ip    = '0;
        tbl_wr_mac   = '0;

        repeat (2) @(negedge AXI_ACLK);
        checks += 3;
        if (S_AXIS_TREADY !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_tready: got %b, required 0", S_AXIS_TREADY);
        end
        if (M_AXIS_TVALID !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_tvalid: got %b, required 0", M_AXIS_TVALID);
        end
        if (meta_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_meta_ready: got %b, required 0", meta_ready);
        end
        checkOutput(32'd0, 32'd0);
        @(negedge AXI_ACLK);
        AXI_RESET = 1'b0;
        $display("[TB] reset released");

        // Basic hit: entry 3 = 10.0.0.2, egress port 1
        writeEntry(5'd3, 1'b1, 32'h0A00_0002, MAC_A);
        applyStimulus(1, 2, 8'h01, 8'h00, 1'b1, 32'h0A00_0002, 8'h04, 1'b1, 8'h04, MAC_A, PMAC1);
        waitDrain();
        checkOutput(32'd1, 32'd0);

        // Miss: absent next hop, source port 2 -> CPU queue bit 5
        applyStimulus(2, 2, 8'h10, 8'h00, 1'b1, 32'h0A00_0009, 8'h04, 1'b0, 8'h20, '0, '0);
        waitDrain();
        checkOutput(32'd1, 32'd1);

        // Duplicate IP in entries 5 and 2: lowest index (2) wins
        writeEntry(5'd5, 1'b1, 32'h0A00_0005, MAC_E5);
        writeEntry(5'd2, 1'b1, 32'h0A00_0005, MAC_E2);
        writeEntry(5'd7, 1'b1, 32'h0A00_0007, MAC_E7);
        applyStimulus(3, 1, 8'h04, 8'h00, 1'b1, 32'h0A00_0005, 8'h01, 1'b1, 8'h01, MAC_E2, PMAC0);
        waitDrain();
        checkOutput(32'd2, 32'd1);

        // Bypass cases: no LPM route, and DST already set upstream
        applyStimulus(4, 3, 8'h01, 8'h00, 1'b0, 32'h0A00_0002, 8'h10, 1'b0, 8'h00, '0, '0);
        applyStimulus(5, 2, 8'h01, 8'h40, 1'b1, 32'h0A00_0002, 8'h10, 1'b0, 8'h40, '0, '0);
        waitDrain();
        checkOutput(32'd2, 32'd1);

        // Hit towards port 3
        applyStimulus(6, 2, 8'h01, 8'h00, 1'b1, 32'h0A00_0002, 8'h40, 1'b1, 8'h40, MAC_A, PMAC3);
        waitDrain();
        checkOutput(32'd3, 32'd1);

        // Invalidated entry now misses
        writeEntry(5'd3, 1'b0, 32'h0A00_0002, MAC_A);
        applyStimulus(7, 1, 8'h04, 8'h00, 1'b1, 32'h0A00_0002, 8'h01, 1'b0, 8'h08, '0, '0);
        waitDrain();
        checkOutput(32'd3, 32'd2);

        // Back-to-back 1/2/5 beat packets with random back-pressure
        stallEn = 1'b1;
        applyStimulus(8, 1, 8'h01, 8'h00, 1'b1, 32'h0A00_0005, 8'h10, 1'b1, 8'h10, MAC_E2, PMAC2);
        applyStimulus(9, 2, 8'h40, 8'h00, 1'b1, 32'h0A00_00FF, 8'h01, 1'b0, 8'h80, '0, '0);
        applyStimulus(10, 5, 8'h01, 8'h00, 1'b1, 32'h0A00_0007, 8'h04, 1'b1, 8'h04, MAC_E7, PMAC1);
        waitDrain();
        stallEn = 1'b0;
        checkOutput(32'd5, 32'd3);

`ifdef ARP_TTL_REWRITE_EN
        // Expiring TTL on a table hit goes to the CPU queue as a miss
        applyStimulus(11, 2, 8'h02, 8'h00, 1'b1, 32'h0A00_0007, 8'h04, 1'b0, 8'h04, '0, '0, 8'h01);
        waitDrain();
        checkOutput(32'd5, 32'd4);
`endif

        // Reset in the middle of a long packet
        applyStimulus(20, 8, 8'h01, 8'h00, 1'b1, 32'h0A00_0005, 8'h04, 1'b1, 8'h04, MAC_E2, PMAC1);
        startBeats = outBeats;
        n = 0;
        while (outBeats < startBeats + 3 && n < 500) begin
            @(posedge AXI_ACLK);
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("[TB] FAIL mid_packet_wait: got %0d beats, required 3", outBeats - startBeats);
        end
        #2;
        AXI_RESET = 1'b1;
        abortDrv  = 1'b1;
        inQ.delete();
        metaQ.delete();
        expQ.delete();
        #1;
        checks++;
        if (M_AXIS_TVALID !== 1'b0) begin
            errors++;
            $display("[TB] FAIL tvalid_in_reset: got %b, required 0", M_AXIS_TVALID);
        end
        repeat (3) @(negedge AXI_ACLK);
        checkOutput(32'd0, 32'd0);
        @(negedge AXI_ACLK);
        AXI_RESET = 1'b0;
        abortDrv  = 1'b0;
        $display("[TB] reset released after mid-packet flush");

        // Table was cleared by reset; repopulate and send a fresh packet
        writeEntry(5'd1, 1'b1, 32'h0A00_0002, MAC_A);
        applyStimulus(21, 3, 8'h02, 8'h00, 1'b1, 32'h0A00_0002, 8'h01, 1'b1, 8'h01, MAC_A, PMAC0);
        waitDrain();
        checkOutput(32'd1, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
